z16_instr_encoder: RTL and testbench
====================================

Z16_INSTR_ENCODER -- requirements
Module: z16_instr_encoder

Interface
REQ-001 The module SHALL provide these ports (name, direction, width, meaning), clock and reset first:
- i_clk  in  1  single clock; all state changes on its rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  begin a load session at i_base_addr
- i_base_addr  in  16  first instruction-memory address
- i_valid  in  1  instruction fields present
- o_ready  out  1  encoder accepts fields this cycle
- i_last  in  1  qualifies the accepted item as the final one
- i_opcode, i_rd, i_rs1, i_rs2  in  4 each  instruction fields
- i_imm  in  16  signed immediate
- o_mem_wen  out  1  write request to instruction memory
- o_mem_addr  out  16  write address
- o_mem_wdata  out  16  encoded instruction word
- i_mem_ready  in  1  memory accepts the write this cycle
- o_count  out  16  words written this session
- o_err  out  1  sticky: an item was rejected
- o_done  out  1  session complete

Function
REQ-002 The module SHALL implement three states: IDLE, RUN and DONE.
REQ-003 From IDLE or DONE, i_start SHALL move the FSM to RUN and load the address counter from i_base_addr; it SHALL also clear o_count, o_err and o_done.
REQ-004 i_start SHALL be ignored while in RUN.
REQ-005 o_ready SHALL equal (state==RUN) AND (NOT o_mem_wen OR i_mem_ready).
REQ-006 An item SHALL be accepted only on a cycle where i_valid and o_ready are both 1.
REQ-007 The encoding SHALL be word[3:0]=opcode in every case, with the remaining bits packed per opcode:
- opcodes 0x0-0x8 and 0xC-0xF: [7:4]=rd, [11:8]=rs1, [15:12]=rs2
- opcode 0x9: [7:4]=rd, [15:8]=imm[7:0]; i_rs1 and i_rs2 are ignored
- opcode 0xA: [7:4]=rd, [11:8]=rs1, [15:12]=imm[3:0]
- opcode 0xB: [7:4]=imm[3:0], [11:8]=rs1, [15:12]=rs2
REQ-008 The immediate SHALL be range-checked as a signed 16-bit value:
- opcode 9 requires -128..127
- opcodes A and B require -8..7
- all other opcodes perform no check
REQ-009 A valid accepted item SHALL appear on the next cycle as o_mem_wen=1, with o_mem_addr equal to the current counter and o_mem_wdata equal to the encoded word (latency 1).
REQ-010 o_mem_wen, o_mem_addr and o_mem_wdata SHALL hold stable until a cycle with i_mem_ready=1.
REQ-011 On a write handshake (wen AND i_mem_ready):
- the address counter SHALL increment by 1, wrapping 0xFFFF->0x0000
- o_count SHALL increment, saturating at 0xFFFF
- o_mem_wen SHALL drop unless a new item is accepted in the same cycle
REQ-012 An out-of-range item SHALL still complete its handshake, SHALL produce no write, SHALL leave the counter and o_count unchanged, and SHALL set o_err.
REQ-013 An accepted item with i_last=1 SHALL move the FSM to DONE once its write handshake completes, or on the next cycle if the item was rejected; o_done=1 SHALL be driven while in DONE.
REQ-014 In IDLE and DONE, o_ready SHALL be 0 and further i_valid SHALL be ignored.

Reset
REQ-015 While i_rst=1, the module SHALL force:
- state to IDLE
- o_mem_wen, o_ready, o_done and o_err to 0
- o_count, o_mem_addr, o_mem_wdata and the address counter to 0x0000
REQ-016 A write pending at reset SHALL be discarded and never re-issued.
REQ-017 i_rst SHALL take priority over i_start and all other inputs in the same cycle.

Verification
REQ-018 Scenario: i_start with base 0x0010, then op=1 rd=3 rs1=4 rs2=5 -> next cycle wen=1, addr 0x0010, wdata 0x5431, o_count=1.
REQ-019 Scenario: op=9 rd=2 imm=0xFFFD -> wdata 0xFD29; then op=A rd=6 rs1=7 imm=0xFFFF -> wdata 0xF76A at the next address.
REQ-020 Scenario: op=B rs1=1 rs2=2 imm=5 -> wdata 0x215B; then op=A imm=8 -> no write, o_err=1, o_count unchanged.
REQ-021 Scenario: i_mem_ready=0 for 3 cycles during a write -> wen, addr and wdata held and o_ready=0 for those cycles; the write completes once i_mem_ready=1.
REQ-022 Scenario: base 0xFFFF, two valid items, the second with i_last=1 -> addrs 0xFFFF then 0x0000; o_done=1 after the second handshake; a later i_start clears o_done and o_count.
REQ-023 Scenario: i_rst asserted while a write is stalled -> next cycle wen=0, FSM in IDLE, o_count=0; no write appears after reset releases.

Source files
------------

// File: rtl/z16_instr_encoder_if.sv
// Bundle of the session-control, instruction-field and memory-write signals of the z16 encoder.
// The slave modport is the encoder side; the master modport is the driver/memory side.
interface z16_instr_encoder_if;
   logic        i_start;
   logic [15:0] i_base_addr;
   logic        i_valid;
   logic        o_ready;
   logic        i_last;
   logic [3:0]  i_opcode;
   logic [3:0]  i_rd;
   logic [3:0]  i_rs1;
   logic [3:0]  i_rs2;
   logic [15:0] i_imm;
   logic        o_mem_wen;
   logic [15:0] o_mem_addr;
   logic [15:0] o_mem_wdata;
   logic        i_mem_ready;
   logic [15:0] o_count;
   logic        o_err;
   logic        o_done;

   modport slave (
      input  i_start, i_base_addr, i_valid, i_last, i_opcode, i_rd, i_rs1, i_rs2,
             i_imm, i_mem_ready,
      output o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_err, o_done
   );

   modport master (
      output i_start, i_base_addr, i_valid, i_last, i_opcode, i_rd, i_rs1, i_rs2,
             i_imm, i_mem_ready,
      input  o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_err, o_done
   );
endinterface

// File: rtl/z16_instr_encoder.sv
// Packs instruction fields into 16-bit words and streams them to instruction memory
// from a base address, with immediate range checking and a one-deep write stage.
module z16_instr_encoder (
   input logic                  i_clk,
   input logic                  i_rst,
   z16_instr_encoder_if.slave   bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic signed [15:0] IMM8_MIN = -16'sd128;
   localparam logic signed [15:0] IMM8_MAX = 16'sd127;
   localparam logic signed [15:0] IMM4_MIN = -16'sd8;
   localparam logic signed [15:0] IMM4_MAX = 16'sd7;

   logic [1:0]  state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] count_q, count_d;
   logic        err_q, err_d;
   logic        wen_q, wen_d;
   logic [15:0] wdata_q, wdata_d;
   logic        last_q, last_d;

   logic               ready;
   logic               accept;
   logic               handshake;
   logic               in_range;
   logic [15:0]        word;
   logic signed [15:0] imm_s;

   always_comb begin
      imm_s     = bus.i_imm;
      ready     = (state_q == ST_RUN) && (!wen_q || bus.i_mem_ready);
      accept    = bus.i_valid && ready;
      handshake = wen_q && bus.i_mem_ready;

      word     = '0;
      in_range = 1'b1;
      case (bus.i_opcode)
         4'h9: begin
            word     = {bus.i_imm[7:0], bus.i_rd, bus.i_opcode};
            in_range = (imm_s >= IMM8_MIN) && (imm_s <= IMM8_MAX);
         end
         4'hA: begin
            word     = {bus.i_imm[3:0], bus.i_rs1, bus.i_rd, bus.i_opcode};
            in_range = (imm_s >= IMM4_MIN) && (imm_s <= IMM4_MAX);
         end
         4'hB: begin
            word     = {bus.i_rs2, bus.i_rs1, bus.i_imm[3:0], bus.i_opcode};
            in_range = (imm_s >= IMM4_MIN) && (imm_s <= IMM4_MAX);
         end
         default: word = {bus.i_rs2, bus.i_rs1, bus.i_rd, bus.i_opcode};
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      err_d   = err_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      last_d  = last_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.i_start) begin
               state_d = ST_RUN;
               addr_d  = bus.i_base_addr;
               count_d = '0;
               err_d   = 1'b0;
               wen_d   = 1'b0;
               last_d  = 1'b0;
            end
         end
         ST_RUN: begin
            if (handshake) begin
               addr_d  = addr_q + 16'd1;
               count_d = (count_q == '1) ? count_q : count_q + 16'd1;
               wen_d   = 1'b0;
               if (last_q) state_d = ST_DONE;
            end
            // Once the final write retires the session is over, so a same-cycle item is dropped.
            if (accept && !(handshake && last_q)) begin
               if (in_range) begin
                  wen_d   = 1'b1;
                  wdata_d = word;
                  last_d  = bus.i_last;
               end else begin
                  err_d = 1'b1;
                  if (bus.i_last) state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
      end
   end

   // The address counter doubles as the write address: it only advances on a handshake.
   assign bus.o_ready     = ready;
   assign bus.o_mem_wen   = wen_q;
   assign bus.o_mem_addr  = addr_q;
   assign bus.o_mem_wdata = wdata_q;
   assign bus.o_count     = count_q;
   assign bus.o_err       = err_q;
   assign bus.o_done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_z16_instr_encoder.sv
// Directed self-checking bench for z16_instr_encoder: encodings, range checks,
// stalls, address wrap, session end/restart and reset during a stalled write.
module tb_z16_instr_encoder;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   z16_instr_encoder_if bus ();

   z16_instr_encoder dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic item(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [15:0] imm, input logic last);
      bus.i_valid  = 1'b1;
      bus.i_opcode = op;
      bus.i_rd     = rd;
      bus.i_rs1    = rs1;
      bus.i_rs2    = rs2;
      bus.i_imm    = imm;
      bus.i_last   = last;
   endtask

   initial begin
      rst             = 1'b1;
      bus.i_start     = 1'b0;
      bus.i_base_addr = '0;
      bus.i_valid     = 1'b0;
      bus.i_last      = 1'b0;
      bus.i_opcode    = '0;
      bus.i_rd        = '0;
      bus.i_rs1       = '0;
      bus.i_rs2       = '0;
      bus.i_imm       = '0;
      bus.i_mem_ready = 1'b1;
      step();
      step();
      chk("rst_wen",   16'(bus.o_mem_wen), 16'h0);
      chk("rst_ready", 16'(bus.o_ready),   16'h0);
      chk("rst_done",  16'(bus.o_done),    16'h0);
      chk("rst_err",   16'(bus.o_err),     16'h0);
      chk("rst_count", bus.o_count,        16'h0000);
      chk("rst_addr",  bus.o_mem_addr,     16'h0000);
      chk("rst_wdata", bus.o_mem_wdata,    16'h0000);
      rst = 1'b0;

      // valid while idle is ignored
      item(4'h1, 4'h1, 4'h1, 4'h1, 16'h0, 1'b0);
      step();
      chk("idle_ready", 16'(bus.o_ready),   16'h0);
      chk("idle_wen",   16'(bus.o_mem_wen), 16'h0);
      bus.i_valid = 1'b0;

      // session at 0x0010
      bus.i_start = 1'b1; bus.i_base_addr = 16'h0010;
      step();
      bus.i_start = 1'b0;
      chk("run_ready", 16'(bus.o_ready), 16'h1);
      chk("run_addr",  bus.o_mem_addr,   16'h0010);

      item(4'h1, 4'h3, 4'h4, 4'h5, 16'h0, 1'b0);
      step();
      bus.i_valid = 1'b0;
      chk("r1_wen",   16'(bus.o_mem_wen), 16'h1);
      chk("r1_addr",  bus.o_mem_addr,     16'h0010);
      chk("r1_wdata", bus.o_mem_wdata,    16'h5431);
      step();
      chk("r1_count", bus.o_count,        16'h0001);
      chk("r1_wdrop", 16'(bus.o_mem_wen), 16'h0);

      // op9 then opA back to back
      item(4'h9, 4'h2, 4'hE, 4'hE, 16'hFFFD, 1'b0);
      step();
      chk("i9_addr",  bus.o_mem_addr,  16'h0011);
      chk("i9_wdata", bus.o_mem_wdata, 16'hFD29);
      item(4'hA, 4'h6, 4'h7, 4'h0, 16'hFFFF, 1'b0);
      step();
      bus.i_valid = 1'b0;
      chk("ia_wen",   16'(bus.o_mem_wen), 16'h1);
      chk("ia_addr",  bus.o_mem_addr,     16'h0012);
      chk("ia_wdata", bus.o_mem_wdata,    16'hF76A);
      chk("ia_count", bus.o_count,        16'h0002);
      step();
      chk("ia_count2", bus.o_count, 16'h0003);

      // opB, then out-of-range opA
      item(4'hB, 4'h0, 4'h1, 4'h2, 16'h0005, 1'b0);
      step();
      bus.i_valid = 1'b0;
      chk("ib_addr",  bus.o_mem_addr,  16'h0013);
      chk("ib_wdata", bus.o_mem_wdata, 16'h215B);
      step();
      chk("ib_count", bus.o_count, 16'h0004);
      item(4'hA, 4'h1, 4'h1, 4'h0, 16'h0008, 1'b0);
      step();
      bus.i_valid = 1'b0;
      chk("rej_wen",   16'(bus.o_mem_wen), 16'h0);
      chk("rej_err",   16'(bus.o_err),     16'h1);
      chk("rej_count", bus.o_count,        16'h0004);
      chk("rej_addr",  bus.o_mem_addr,     16'h0014);

      // op9 boundaries: 128 rejected, -128 accepted
      item(4'h9, 4'h1, 4'h0, 4'h0, 16'h0080, 1'b0);
      step();
      chk("b128_wen", 16'(bus.o_mem_wen), 16'h0);
      item(4'h9, 4'h1, 4'h0, 4'h0, 16'hFF80, 1'b0);
      step();
      bus.i_valid = 1'b0;
      chk("bm128_wen",   16'(bus.o_mem_wen), 16'h1);
      chk("bm128_wdata", bus.o_mem_wdata,    16'h8019);
      chk("bm128_addr",  bus.o_mem_addr,     16'h0014);
      step();
      chk("bm128_count", bus.o_count, 16'h0005);

      // stall for 3 cycles
      bus.i_mem_ready = 1'b0;
      item(4'h2, 4'h1, 4'h2, 4'h3, 16'h0, 1'b0);
      step();
      bus.i_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stall_wen",   16'(bus.o_mem_wen), 16'h1);
         chk("stall_addr",  bus.o_mem_addr,     16'h0015);
         chk("stall_wdata", bus.o_mem_wdata,    16'h3212);
         chk("stall_ready", 16'(bus.o_ready),   16'h0);
         step();
      end
      bus.i_mem_ready = 1'b1;
      #1;
      chk("stall_rel_ready", 16'(bus.o_ready), 16'h1);
      step();
      chk("stall_count", bus.o_count,        16'h0006);
      chk("stall_wen0",  16'(bus.o_mem_wen), 16'h0);

      // start ignored in RUN
      bus.i_start = 1'b1; bus.i_base_addr = 16'h0100;
      step();
      bus.i_start = 1'b0;
      chk("run_start_addr",  bus.o_mem_addr, 16'h0016);
      chk("run_start_count", bus.o_count,    16'h0006);

      // last item ends session
      item(4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b1);
      step();
      bus.i_valid = 1'b0;
      chk("last_wen",  16'(bus.o_mem_wen), 16'h1);
      chk("last_done", 16'(bus.o_done),    16'h0);
      step();
      chk("done_done",  16'(bus.o_done),  16'h1);
      chk("done_ready", 16'(bus.o_ready), 16'h0);
      chk("done_count", bus.o_count,      16'h0007);
      item(4'h1, 4'h1, 4'h1, 4'h1, 16'h0, 1'b0);
      step();
      bus.i_valid = 1'b0;
      chk("done_ign_wen", 16'(bus.o_mem_wen), 16'h0);

      // base 0xFFFF, wrap
      bus.i_start = 1'b1; bus.i_base_addr = 16'hFFFF;
      step();
      bus.i_start = 1'b0;
      chk("rs_done",  16'(bus.o_done), 16'h0);
      chk("rs_count", bus.o_count,     16'h0000);
      chk("rs_err",   16'(bus.o_err),  16'h0);
      item(4'h3, 4'h1, 4'h1, 4'h1, 16'h0, 1'b0);
      step();
      chk("w1_addr",  bus.o_mem_addr,  16'hFFFF);
      chk("w1_wdata", bus.o_mem_wdata, 16'h1113);
      item(4'h4, 4'h2, 4'h2, 4'h2, 16'h0, 1'b1);
      step();
      bus.i_valid = 1'b0;
      chk("w2_addr",  bus.o_mem_addr,  16'h0000);
      chk("w2_wdata", bus.o_mem_wdata, 16'h2224);
      chk("w2_done",  16'(bus.o_done), 16'h0);
      step();
      chk("w2_done1", 16'(bus.o_done), 16'h1);
      chk("w2_count", bus.o_count,     16'h0002);

      // rejected last item ends session on the next cycle
      bus.i_start = 1'b1; bus.i_base_addr = 16'h0020;
      step();
      bus.i_start = 1'b0;
      chk("rs2_done",  16'(bus.o_done), 16'h0);
      chk("rs2_count", bus.o_count,     16'h0000);
      item(4'h9, 4'h1, 4'h0, 4'h0, 16'h0100, 1'b1);
      step();
      bus.i_valid = 1'b0;
      chk("rl_done", 16'(bus.o_done),    16'h1);
      chk("rl_err",  16'(bus.o_err),     16'h1);
      chk("rl_wen",  16'(bus.o_mem_wen), 16'h0);

      // reset during a stalled write, with start held alongside reset
      bus.i_start = 1'b1; bus.i_base_addr = 16'h0030;
      step();
      bus.i_start = 1'b0;
      bus.i_mem_ready = 1'b0;
      item(4'h5, 4'h1, 4'h1, 4'h1, 16'h0, 1'b0);
      step();
      bus.i_valid = 1'b0;
      chk("pre_rst_wen", 16'(bus.o_mem_wen), 16'h1);
      rst = 1'b1; bus.i_start = 1'b1;
      step();
      chk("mr_wen",   16'(bus.o_mem_wen), 16'h0);
      chk("mr_ready", 16'(bus.o_ready),   16'h0);
      chk("mr_count", bus.o_count,        16'h0000);
      chk("mr_addr",  bus.o_mem_addr,     16'h0000);
      chk("mr_wdata", bus.o_mem_wdata,    16'h0000);
      chk("mr_done",  16'(bus.o_done),    16'h0);
      rst = 1'b0; bus.i_start = 1'b0; bus.i_mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_wen",   16'(bus.o_mem_wen), 16'h0);
         chk("post_rst_ready", 16'(bus.o_ready),   16'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
